// File: rtl/refresh_pkg.sv
// Shared types and default sizing for the DRAM refresh scheduler.
package refresh_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } refresh_state_t;

    localparam int REFRESH_LEN_DEFAULT    = 40;
    localparam int REFRESH_QDEPTH_DEFAULT = 3;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; RESET_PREV sets the assumed previous level
// so a level already high when reset releases is not seen as an edge.
module rise_detect #(
    parameter logic RESET_PREV = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_prev <= RESET_PREV;
        else          r_prev <= d;
    end

    assign rise = d & ~r_prev;

endmodule

// File: rtl/refresh_scheduler.sv
// Queued DRAM refresh-window generator: LEN-clock windows launched on cpu_en slots.
// Define REFRESH_HOLD_EN to let the hold input defer launches.
module refresh_scheduler
    import refresh_pkg::*;
#(
    parameter int LEN    = REFRESH_LEN_DEFAULT,
    parameter int QDEPTH = REFRESH_QDEPTH_DEFAULT,
    parameter int CW     = $clog2(LEN + 1),
    parameter int PW     = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_en,
    input  logic          start,
    input  logic          hold,
    output logic          refresh,
    output logic [PW-1:0] pending,
    output logic          overflow
);

    refresh_state_t r_state, w_state_nxt;
    logic [CW-1:0]  r_ctr, w_ctr_nxt;
    logic [PW-1:0]  r_pend, w_pend_nxt;
    logic           r_ovf, w_ovf_nxt;
    logic           w_rise, w_launch, w_hold_eff;

`ifdef REFRESH_HOLD_EN
    assign w_hold_eff = hold;
`else
    // Port kept for a uniform interface; the feature is compiled out.
    assign w_hold_eff = hold & 1'b0;
`endif

    rise_detect #(
        .RESET_PREV (1'b1)
    ) u_rise (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (start),
        .rise    (w_rise)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ctr   <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ctr   <= w_ctr_nxt;
            r_pend  <= w_pend_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ctr_nxt   = r_ctr;
        w_launch    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pend != '0 && cpu_en && !w_hold_eff) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ACTIVE;
                    w_ctr_nxt   = CW'(1);
                end
            end
            ACTIVE: begin
                // The exit cycle never launches, guaranteeing a low gap between windows.
                if (r_ctr == CW'(LEN)) begin
                    w_state_nxt = IDLE;
                    w_ctr_nxt   = '0;
                end else begin
                    w_ctr_nxt = r_ctr + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ctr_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_pend_nxt = r_pend;
        w_ovf_nxt  = r_ovf;
        if (w_rise && !w_launch) begin
            if (r_pend < PW'(QDEPTH)) w_pend_nxt = r_pend + PW'(1);
            else                      w_ovf_nxt  = 1'b1;
        end else if (w_launch && !w_rise) begin
            w_pend_nxt = r_pend - PW'(1);
        end
    end

    assign refresh  = (r_state == ACTIVE);
    assign pending  = r_pend;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_refresh_scheduler.sv
// Directed bench for refresh_scheduler with a time-based reference model.
module tb_refresh_scheduler;
    import refresh_pkg::*;

    localparam int LEN    = REFRESH_LEN_DEFAULT;
    localparam int QDEPTH = REFRESH_QDEPTH_DEFAULT;
    localparam int PW     = $clog2(QDEPTH + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cpu_en = 1'b0;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic          refresh;
    logic [PW-1:0] pending;
    logic          overflow;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 1'b0;

    refresh_scheduler #(.LEN(LEN), .QDEPTH(QDEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cpu_en   (cpu_en),
        .start    (start),
        .hold     (hold),
        .refresh  (refresh),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: windows are intervals of edge indices, not a state machine.
    int m_cyc       = 0;
    int m_win_start = -100000;
    int m_next_ok   = 0;
    int m_pend      = 0;
    bit m_ovf       = 1'b0;
    bit m_prev      = 1'b1;
    bit m_rise, m_launch, m_hold_eff;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pend      = 0;
            m_ovf       = 1'b0;
            m_prev      = 1'b1;
            m_win_start = -100000;
            m_next_ok   = 0;
        end else begin
`ifdef REFRESH_HOLD_EN
            m_hold_eff = hold;
`else
            m_hold_eff = 1'b0;
`endif
            m_rise   = start && !m_prev;
            m_launch = (m_pend > 0) && cpu_en && !m_hold_eff && (m_cyc >= m_next_ok);
            if (m_launch) begin
                m_win_start = m_cyc;
                m_next_ok   = m_cyc + LEN + 1;
            end
            if (m_rise && !m_launch) begin
                if (m_pend < QDEPTH) m_pend = m_pend + 1;
                else                 m_ovf  = 1'b1;
            end else if (m_launch && !m_rise) begin
                m_pend = m_pend - 1;
            end
            m_prev = start;
            m_cyc  = m_cyc + 1;
        end
    end

    function automatic bit model_refresh();
        int e = m_cyc - 1;
        return (e >= m_win_start) && (e < m_win_start + LEN);
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            n_checks = n_checks + 3;
            if (refresh !== model_refresh()) begin
                n_err = n_err + 1;
                $display("FAIL model_refresh t=%0t: got %0d expected %0d", $time, refresh, model_refresh());
            end
            if (pending !== PW'(m_pend)) begin
                n_err = n_err + 1;
                $display("FAIL model_pending t=%0t: got %0d expected %0d", $time, pending, m_pend);
            end
            if (overflow !== m_ovf) begin
                n_err = n_err + 1;
                $display("FAIL model_overflow t=%0t: got %0d expected %0d", $time, overflow, m_ovf);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // 0: cpu_en driven by hand, 1: every clock, 2: every 6th clock.
    int cpu_mode = 1;
    int tb_cyc   = 0;

    task automatic step();
        @(posedge clk);
        #1;
        tb_cyc = tb_cyc + 1;
        if (cpu_mode == 1)      cpu_en = 1'b1;
        else if (cpu_mode == 2) cpu_en = (tb_cyc % 6 == 0);
    endtask

    task automatic pulse();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic run_count(input int n, output int hi, output int rises);
        bit prev;
        hi    = 0;
        rises = 0;
        prev  = refresh;
        for (int i = 0; i < n; i++) begin
            step();
            if (refresh) hi = hi + 1;
            if (refresh && !prev) rises = rises + 1;
            prev = refresh;
        end
    endtask

    int hi, rises;

    initial begin
        repeat (3) step();
        chk("reset_refresh", refresh, 0);
        chk("reset_pending", pending, 0);
        chk("reset_overflow", overflow, 0);
        reset_n = 1'b1;
        chk_on  = 1'b1;
        step();

        // Single request, cpu_en every clock: pinned 2-clock latency and 40-clock window.
        cpu_mode = 1;
        start = 1'b1;
        step();
        chk("single_pend_after_edge", pending, 1);
        chk("single_refresh_not_yet", refresh, 0);
        start = 1'b0;
        step();
        chk("single_refresh_rise", refresh, 1);
        chk("single_pend_drained", pending, 0);
        run_count(60, hi, rises);
        chk("single_window_len", hi + 1, LEN);

        // Single request with sparse cpu_en slots.
        cpu_mode = 2;
        pulse();
        run_count(70, hi, rises);
        chk("sparse_window_len", hi, LEN);
        chk("sparse_pend_drained", pending, 0);

        // Three requests queued behind a running window.
        cpu_mode = 1;
        pulse();
        chk("queue_first_launch", refresh, 1);
        repeat (3) pulse();
        chk("queue_pending3", pending, 3);
        run_count(220, hi, rises);
        chk("queue_extra_windows", rises, 3);
        chk("queue_pend_drained", pending, 0);

        // Overflow: seven requests during one window, depth three.
        pulse();
        repeat (7) pulse();
        chk("ovf_pending_sat", pending, 3);
        chk("ovf_flag", overflow, 1);
        run_count(220, hi, rises);
        chk("ovf_extra_windows", rises, 3);
        chk("ovf_sticky", overflow, 1);

        // Reset mid-window with two requests queued; start held high through release.
        pulse();
        repeat (2) pulse();
        repeat (15) step();
        chk("prereset_pending", pending, 2);
        chk("prereset_refresh", refresh, 1);
        reset_n = 1'b0;
        start   = 1'b1;
        #1;
        chk("async_reset_refresh", refresh, 0);
        chk("async_reset_pending", pending, 0);
        chk("async_reset_overflow", overflow, 0);
        step();
        step();
        reset_n = 1'b1;
        repeat (5) step();
        chk("held_start_no_req", pending, 0);
        chk("held_start_no_win", refresh, 0);

        // Request edge coincides with a launch while the queue is full.
        cpu_mode = 0;
        cpu_en   = 1'b0;
        start    = 1'b0;
        step();
        repeat (3) pulse();
        chk("coinc_pending_full", pending, 3);
        start  = 1'b1;
        cpu_en = 1'b1;
        step();
        chk("coinc_pend_unchanged", pending, 3);
        chk("coinc_no_overflow", overflow, 0);
        chk("coinc_launched", refresh, 1);
        start    = 1'b0;
        cpu_mode = 1;
        run_count(220, hi, rises);
        chk("coinc_extra_windows", rises, 3);
        chk("coinc_pend_drained", pending, 0);

        // Hold behaviour.
        hold = 1'b1;
        pulse();
`ifdef REFRESH_HOLD_EN
        chk("hold_blocks", refresh, 0);
        repeat (98) step();
        chk("hold_still_blocked", refresh, 0);
        chk("hold_still_pending", pending, 1);
        hold = 1'b0;
        step();
        chk("hold_release_launch", refresh, 1);
`else
        chk("hold_ignored_launch", refresh, 1);
        chk("hold_ignored_pend", pending, 0);
`endif
        hi = 1;
        begin
            int h1, r1;
            run_count(9, h1, r1);
            hi = hi + h1;
            hold = 1'b1;
            run_count(50, h1, r1);
            hi = hi + h1;
        end
        chk("hold_midwindow_len", hi, LEN);
        hold = 1'b0;
        repeat (3) step();

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/refresh_scheduler.md
# refresh_scheduler

Parametrised DRAM refresh-window generator for the console core. It queues refresh requests from the video timing logic via rising edges of `start`. Each window starts on a CPU enable slot and holds `refresh` high for exactly `LEN` clocks. Unlike the single-shot generator, it buffers up to `QDEPTH` overlapping requests, flags dropped requests, and can defer windows while a bus-master `hold` is asserted.

## Interface
- `LEN`, 40: refresh window length in clocks (≥2).
- `QDEPTH`, 3: maximum pending requests (≥1).
- `CW`, $clog2(LEN+1): counter width, derived; do not override.
- `PW`, $clog2(QDEPTH+1): pending-count width, derived; do not override.

Ports:
- `clk`  in  1  system clock. One clock domain only.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_en`  in  1  CPU clock-enable slot strobe.
- `start`  in  1  refresh request level; a rising edge is one request.
- `hold`  in  1  defer new windows (DMA or other bus master busy).
- `refresh`  out  1  high during a refresh window.
- `pending`  out  PW  number of queued, not-yet-started requests.
- `overflow`  out  1  sticky flag: a request was dropped.

## Operation
- Edge detect:
  - `start_prev` is registered every clock and resets to 1, so a `start` level already high at reset release is not a request.
  - `rise = start & ~start_prev`.
- Pending counter `pend`:
  - Request only: if `pend < QDEPTH`, increment; otherwise `pend` is unchanged and `overflow` is set to 1.
  - Launch only: decrement.
  - Request and launch in the same cycle: `pend` is unchanged, and `overflow` is not set even at `QDEPTH`.
- FSM states:
  - IDLE: `ctr` = 0. If `pend != 0 & cpu_en & ~hold_eff`, launch: go to ACTIVE, set `ctr` to 1, decrement `pend`.
  - ACTIVE: `ctr` increments every clock, not gated by `cpu_en`. When `ctr == LEN`, set `ctr` to 0 and go to IDLE. No launch is evaluated in the cycle ACTIVE exits.
- Outputs:
  - `refresh = (state == ACTIVE)`, driven from the register, so `refresh` is high for exactly `LEN` clocks per window.
  - `pending = pend`.
- `hold_eff = hold` when `REFRESH_HOLD_EN` is defined; otherwise it is 0.
  - `hold` only blocks launches. A window already running always completes.
- Requests arriving during ACTIVE are queued and never restart the running window.
- `overflow` is cleared only by reset.
- Reset values, applied at any time including mid-window: state IDLE, `ctr` 0, `pend` 0, `overflow` 0, `refresh` 0, `start_prev` 1.

## Timing
- Request at clock edge k: `pend` updates after edge k.
- Earliest launch is at edge k+1 when `cpu_en=1` there; `refresh` goes high after edge k+1.
- Minimum latency from edge detection to `refresh` is 2 clocks, matching the previous generator.
- A window started at edge m deasserts `refresh` after edge m+LEN.
- With a request queued, the next launch is the first `cpu_en` edge at or after m+LEN+1. At least one low cycle separates consecutive windows.
- `pending` and `overflow` change only on clock edges.

## Configuration
- `REFRESH_HOLD_EN`:
  - Defined: `hold` defers launches as above.
  - Undefined: the `hold` port still exists but is ignored (tie-off internally, lint waiver).

## Structure
- Package `refresh_pkg` holds:
  - `refresh_state_t` enum {IDLE, ACTIVE}.
  - `REFRESH_LEN_DEFAULT` = 40.
  - `REFRESH_QDEPTH_DEFAULT` = 3.
- Sub-module `rise_detect` (parameter `RESET_PREV`): registered previous value, `rise` output, async active-low reset.

## Test plan
- Single request, `cpu_en` every 6th clock, LEN=40 → `refresh` rises on the first `cpu_en` edge after the `pend` update, lasts exactly 40 clocks; `pending` goes 1→0.
- Three edges during one active window (QDEPTH=3) → `pending`=3; three more 40-clock windows follow, each separated by ≥1 low clock and aligned to `cpu_en`.
- Four edges while `pend`=3 and no launch possible → `overflow`=1, `pending` stays 3, only 3 extra windows run.
- `REFRESH_HOLD_EN` defined, request with `hold`=1 for 100 clocks → no window until the first `cpu_en` after `hold` falls. Raising `hold` mid-window does not shorten it. Macro undefined → `hold` has no effect.
- `reset_n` low at `ctr`=20 with `pend`=2 → `refresh`, `pending`, `overflow` are 0 immediately. `start` held high through release → no request.
- Request edge coinciding with a launch edge at `pend`=QDEPTH → `pend` unchanged, `overflow` stays 0.
